packet_rr_scheduler: RTL and testbench
======================================

PACKET_RR_SCHEDULER -- requirements
Module: packet_rr_scheduler

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; DW, default 8, data width; MAX_BEATS, default 64, packet length limit.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 req_valid  in  NREQ  per-requester beat valid.
REQ-005 req_data  in  NREQ*DW  per-requester beat data; requester i occupies bits [i*DW +: DW].
REQ-006 req_sop / req_eop  in  NREQ each  per-requester start/end-of-packet marks.
REQ-007 req_ready  out  NREQ  per-requester beat accept.
REQ-008 out_valid, out_sop, out_eop  out  1 each  registered output beat qualifiers.
REQ-009 out_d  out  DW  registered output data.
REQ-010 out_src  out  clog2(NREQ)  index of the requester that sourced out_d.
REQ-011 out_ready  in  1  downstream accept.
REQ-012 err_clr  in  1  clears sticky errors.
REQ-013 err_orphan, err_len  out  1 each  sticky error flags.
REQ-014 busy  out  1  high when state != IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, XFER and DROP.
REQ-016 IDLE: eligible = req_valid & req_sop. Round-robin search SHALL start at last_grant+1, wrapping modulo NREQ.
REQ-017 IDLE with any eligible: grant <= first eligible index; state <= XFER on the next edge. There is 1 arbitration cycle per packet, and req_ready is all-zero during it.
REQ-018 IDLE, requester with req_valid=1 and req_sop=0: that beat SHALL be discarded (req_ready[i]=1 for one cycle) and err_orphan set. When several such requesters exist, the lowest index goes first. Discarding SHALL occur only in cycles with no eligible requester.
REQ-019 XFER: req_ready[grant] = (!out_valid | out_ready). All other req_ready bits = 0.
REQ-020 An accepted beat SHALL appear on out_d/out_sop/out_eop/out_src with out_valid=1 on the following cycle (latency 1).
REQ-021 out_valid SHALL stay high and the output SHALL stay stable until out_ready=1. Sustained throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-022 XFER accept with req_eop=1: last_grant <= grant; state <= IDLE. A single-beat packet (sop=eop=1) SHALL be legal.
REQ-023 beat_cnt SHALL be cleared on grant and increment per accepted beat, saturating at MAX_BEATS.
REQ-024 When the MAX_BEATS-th beat is accepted without req_eop: forward it with out_eop forced to 1, set err_len, state <= DROP.
REQ-025 DROP: req_ready[grant]=1 and beats are discarded (not forwarded). On accept with req_eop=1: last_grant <= grant; state <= IDLE.
REQ-026 A req_sop=1 beat accepted mid-packet (XFER, beat_cnt>0) SHALL be forwarded unchanged. No error is raised.
REQ-027 Sticky flags SHALL be cleared by err_clr; a set event in the same cycle as err_clr wins.
REQ-028 The requester that just completed a packet SHALL have lowest priority in the next arbitration. No requester is granted twice while another eligible requester waits.

Reset
REQ-029 rst=0 SHALL asynchronously force: state=IDLE, out_valid=0, out_sop=0, out_eop=0, out_d=0, out_src=0, req_ready=0, err_orphan=0, err_len=0, busy=0, beat_cnt=0, last_grant=NREQ-1 (requester 0 has first priority).
REQ-030 Reset mid-packet SHALL abandon the packet; no partial beat is held after release.
REQ-031 The first arbitration SHALL take place on the first rising edge with rst=1.

Verification
REQ-032 Req0 and req2 each offer a 3-beat packet (0x10..0x12, 0x20..0x22) after reset, with out_ready=1. Required: out_d = 0x10,0x11,0x12 (src 0), then one idle cycle, then 0x20,0x21,0x22 (src 2); sop/eop on the first/last beat of each.
REQ-033 All 4 requesters continuously offer 1-beat packets. Required: out_src sequence 0,1,2,3,0,1,... with one beat every 2 cycles.
REQ-034 Toggle out_ready 1,0,0,1 during a req1 packet. Required: out_d holds its value while out_ready=0, no beat is lost or duplicated, and req_ready[1]=0 while the output is stalled.
REQ-035 MAX_BEATS=4; req3 sends 6 beats with eop on beat 6. Required: 4 beats out, the 4th with out_eop=1, err_len=1, beats 5-6 discarded, busy=0 afterwards.
REQ-036 Req1 presents sop=0 while in IDLE. Required: the beat is discarded, err_orphan=1, no output. err_clr=1 for one cycle then clears err_orphan to 0.
REQ-037 Assert rst=0 on the 2nd beat of a packet. Required: out_valid=0 immediately, all outputs at reset values. After release, requester 0 is granted first if eligible.

Source files
------------

// File: rtl/packet_rr_scheduler.sv
// Round-robin packet scheduler: grants one requester per packet, forwards its beats
// through a single registered output stage and truncates packets longer than MAX_BEATS.
module packet_rr_scheduler #(
   parameter  int unsigned NREQ      = 4,
   parameter  int unsigned DW        = 8,
   parameter  int unsigned MAX_BEATS = 64,
   localparam int unsigned SW        = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int unsigned CW        = $clog2(MAX_BEATS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ-1:0]      req_sop,
   input  logic [NREQ-1:0]      req_eop,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   output logic                 out_sop,
   output logic                 out_eop,
   output logic [DW-1:0]        out_d,
   output logic [SW-1:0]        out_src,
   input  logic                 out_ready,
   input  logic                 err_clr,
   output logic                 err_orphan,
   output logic                 err_len,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

   localparam logic [CW-1:0] MAX_C = CW'(MAX_BEATS);

   state_t          state;
   logic [SW-1:0]   grant;
   logic [SW-1:0]   last_grant;
   logic [SW-1:0]   rr_pick;
   logic [SW-1:0]   orphan_idx;
   logic [CW-1:0]   beat_cnt;
   logic [CW-1:0]   cnt_inc;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] orphan;
   logic [DW-1:0]   gdata;
   logic            rr_found;
   logic            orphan_found;
   logic            accept;
   logic            len_hit;
   int unsigned     idx;

   // Search starts one past the last completed requester, so it gets lowest priority.
   always_comb begin
      eligible     = req_valid & req_sop;
      orphan       = req_valid & ~req_sop;
      rr_pick      = '0;
      rr_found     = 1'b0;
      orphan_idx   = '0;
      orphan_found = 1'b0;
      idx          = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(last_grant) + k) % NREQ;
         if (!rr_found && eligible[SW'(idx)]) begin
            rr_pick  = SW'(idx);
            rr_found = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!orphan_found && orphan[i]) begin
            orphan_idx   = SW'(i);
            orphan_found = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst) begin
         unique case (state)
            IDLE:    if (eligible == '0 && orphan_found) req_ready[orphan_idx] = 1'b1;
            XFER:    req_ready[grant] = !out_valid || out_ready;
            DROP:    req_ready[grant] = 1'b1;
            default: ;
         endcase
      end
      accept  = (state != IDLE) && req_valid[grant] && req_ready[grant];
      gdata   = req_data[32'(grant)*DW +: DW];
      cnt_inc = (beat_cnt == MAX_C) ? beat_cnt : beat_cnt + 1'b1;
      len_hit = (cnt_inc == MAX_C);
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= SW'(NREQ - 1);
         beat_cnt   <= '0;
         out_valid  <= 1'b0;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         out_d      <= '0;
         out_src    <= '0;
         err_orphan <= 1'b0;
         err_len    <= 1'b0;
      end else begin
         // Clears are issued first so a same-cycle set event overrides them.
         if (err_clr) begin
            err_orphan <= 1'b0;
            err_len    <= 1'b0;
         end
         if (out_ready) out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (eligible != '0) begin
                  grant    <= rr_pick;
                  beat_cnt <= '0;
                  state    <= XFER;
               end else if (orphan_found) begin
                  err_orphan <= 1'b1;
               end
            end
            XFER: begin
               if (accept) begin
                  out_valid <= 1'b1;
                  out_d     <= gdata;
                  out_sop   <= req_sop[grant];
                  out_eop   <= req_eop[grant] || len_hit;
                  out_src   <= grant;
                  beat_cnt  <= cnt_inc;
                  if (req_eop[grant]) begin
                     last_grant <= grant;
                     state      <= IDLE;
                  end else if (len_hit) begin
                     err_len <= 1'b1;
                     state   <= DROP;
                  end
               end
            end
            DROP: begin
               if (accept) begin
                  beat_cnt <= cnt_inc;
                  if (req_eop[grant]) begin
                     last_grant <= grant;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_packet_rr_scheduler.sv
// Bench for packet_rr_scheduler: directed scenarios plus randomized traffic scored
// against a queue-based round-robin packet model.
module tb_packet_rr_scheduler;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int MAXB = 4;

   typedef struct packed {
      logic          sop;
      logic          eop;
      logic [DW-1:0] d;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]   req_sop;
   logic [NREQ-1:0]   req_eop;
   logic [NREQ-1:0]   req_ready;
   logic              out_valid;
   logic              out_sop;
   logic              out_eop;
   logic [DW-1:0]     out_d;
   logic [1:0]        out_src;
   logic              out_ready;
   logic              err_clr;
   logic              err_orphan;
   logic              err_len;
   logic              busy;

   beat_t       src_q[NREQ][$];
   beat_t       mdl_q[NREQ][$];
   logic [11:0] exp_q[$];
   bit          rdy_pat[$];
   bit          gap_en;
   bit          rdy_rand;
   bit          held_v;
   logic [11:0] held;
   logic [31:0] vpat;
   logic [NREQ-1:0] snap_rdy;
   int unsigned n_chk;
   int unsigned n_pass;
   int unsigned n_extra;

   packet_rr_scheduler #(
      .NREQ      (NREQ),
      .DW        (DW),
      .MAX_BEATS (MAXB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_sop    (req_sop),
      .req_eop    (req_eop),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_d      (out_d),
      .out_src    (out_src),
      .out_ready  (out_ready),
      .err_clr    (err_clr),
      .err_orphan (err_orphan),
      .err_len    (err_len),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [11:0] mk(input int s, input bit sop, input bit eop, input int d);
      return {s[1:0], sop, eop, d[7:0]};
   endfunction

   task automatic push_beat(input int s, input bit sop, input bit eop, input int d);
      beat_t b;
      b.sop = sop;
      b.eop = eop;
      b.d   = d[7:0];
      src_q[s].push_back(b);
   endtask

   task automatic push_pkt(input int s, input int len, input int base);
      for (int k = 0; k < len; k++) push_beat(s, k == 0, k == len - 1, base + k);
   endtask

   function automatic bit all_empty();
      bit e = 1'b1;
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   // Sources hold their head beat until it is accepted; gaps only inside a packet.
   task automatic drive();
      beat_t b;
      for (int i = 0; i < NREQ; i++) begin
         if (src_q[i].size() > 0) begin
            b = src_q[i][0];
            req_valid[i]         = b.sop || !gap_en || ($urandom_range(0, 3) != 0);
            req_sop[i]           = b.sop;
            req_eop[i]           = b.eop;
            req_data[i*DW +: DW] = b.d;
         end else begin
            req_valid[i]         = 1'b0;
            req_sop[i]           = 1'b0;
            req_eop[i]           = 1'b0;
            req_data[i*DW +: DW] = '0;
         end
      end
      if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
      else if (rdy_rand)      out_ready = ($urandom_range(0, 2) != 0);
      else                    out_ready = 1'b1;
   endtask

   task automatic monitor();
      logic [11:0] cur;
      cur  = {out_src, out_sop, out_eop, out_d};
      vpat = {vpat[30:0], out_valid};
      if (held_v) begin
         check("hold_valid", out_valid, 1);
         check("hold_beat", cur, held);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() > 0) check("beat", cur, exp_q.pop_front());
         else n_extra++;
      end
      held_v = out_valid && !out_ready;
      held   = cur;
   endtask

   task automatic cycle();
      logic [NREQ-1:0] hs;
      @(negedge clk);
      monitor();
      snap_rdy = req_ready;
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (hs[i]) void'(src_q[i].pop_front());
      drive();
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) cycle();
   endtask

   task automatic reset_dut();
      rst    = 1'b0;
      held_v = 1'b0;
      vpat   = '0;
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      exp_q.delete();
      rdy_pat.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic release_rst();
      drive();
      rst = 1'b1;
   endtask

   // Packet-level round robin: every source with packets left is eligible at each arbitration.
   task automatic model_expect(output bit want_err);
      int    last;
      int    s;
      int    k;
      bit    more;
      beat_t b;
      want_err = 1'b0;
      for (int i = 0; i < NREQ; i++) mdl_q[i] = src_q[i];
      last = NREQ - 1;
      more = 1'b1;
      while (more) begin
         s = -1;
         for (int o = 1; o <= NREQ; o++)
            if (s < 0 && mdl_q[(last + o) % NREQ].size() > 0) s = (last + o) % NREQ;
         if (s < 0) begin
            more = 1'b0;
         end else begin
            k = 0;
            do begin
               b = mdl_q[s].pop_front();
               k++;
               if (k <= MAXB) exp_q.push_back(mk(s, b.sop, b.eop || k == MAXB, int'(b.d)));
               if (k == MAXB && !b.eop) want_err = 1'b1;
            end while (!b.eop);
            last = s;
         end
      end
   endtask

   initial begin
      bit want_err;
      int cyc;
      n_chk = 0; n_pass = 0; n_extra = 0;
      gap_en = 1'b0; rdy_rand = 1'b0;
      err_clr = 1'b0; out_ready = 1'b0;
      req_valid = '0; req_sop = '0; req_eop = '0; req_data = '0;

      // Reset values, with traffic already presented while reset is held
      reset_dut();
      push_pkt(0, 3, 'h10);
      push_pkt(2, 3, 'h20);
      drive();
      #2;
      check("rst_out", {out_valid, out_sop, out_eop, out_d, out_src}, 0);
      check("rst_flags", {err_orphan, err_len, busy}, 0);
      check("rst_ready", req_ready, 0);

      // Two 3-beat packets, one idle output cycle between them
      for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, k == 0, k == 2, 'h10 + k));
      for (int k = 0; k < 3; k++) exp_q.push_back(mk(2, k == 0, k == 2, 'h20 + k));
      release_rst();
      run(10);
      check("two_pkt_valid_pat", vpat[9:0], 10'b0011101110);
      check("two_pkt_drained", exp_q.size(), 0);
      check("two_pkt_busy", busy, 0);

      // All requesters with 1-beat packets: strict rotation, one beat per two cycles
      reset_dut();
      for (int p = 0; p < 3; p++)
         for (int s = 0; s < NREQ; s++) begin
            push_pkt(s, 1, s * 16 + p);
            exp_q.push_back(mk(s, 1, 1, s * 16 + p));
         end
      release_rst();
      run(10);
      check("rr_valid_pat", vpat[9:0], 10'b0010101010);
      run(20);
      check("rr_drained", exp_q.size(), 0);

      // Output stall while req1 streams
      reset_dut();
      push_pkt(1, 4, 'h30);
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(1, k == 0, k == 3, 'h30 + k));
      rdy_pat = '{1, 1, 1, 0, 0, 1};
      release_rst();
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (c == 2) check("flow_rdy1", snap_rdy[1], 1);
         if (c == 3 || c == 4) check("stall_rdy1", snap_rdy[1], 0);
      end
      check("stall_drained", exp_q.size(), 0);

      // Over-long packet is truncated at MAXB beats, tail dropped
      reset_dut();
      push_pkt(3, 6, 'h40);
      for (int k = 0; k < MAXB; k++) exp_q.push_back(mk(3, k == 0, k == MAXB - 1, 'h40 + k));
      release_rst();
      run(10);
      check("len_err", err_len, 1);
      check("len_busy", busy, 0);
      check("len_src_drained", src_q[3].size(), 0);
      check("len_drained", exp_q.size(), 0);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      check("len_err_clr", err_len, 0);

      // Orphan beats in IDLE are discarded, lowest index first
      reset_dut();
      push_beat(1, 0, 1, 'h55);
      release_rst();
      cycle();
      check("orphan_rdy", snap_rdy, 4'b0010);
      run(2);
      check("orphan_err", err_orphan, 1);
      check("orphan_src_drained", src_q[1].size(), 0);
      push_beat(1, 0, 0, 'h56);
      push_beat(3, 0, 1, 'h57);
      drive();
      cycle();
      check("orphan_lo_first", snap_rdy, 4'b0010);
      cycle();
      check("orphan_next", snap_rdy, 4'b1000);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      check("orphan_clr", err_orphan, 0);
      push_beat(2, 0, 1, 'h58);
      err_clr = 1'b1;
      drive();
      cycle();
      err_clr = 1'b0;
      check("orphan_set_wins", err_orphan, 1);
      check("orphan_no_out", exp_q.size(), 0);

      // Asynchronous reset in the middle of a packet
      reset_dut();
      push_pkt(0, 1, 'h70);
      push_pkt(1, 3, 'h60);
      exp_q.push_back(mk(0, 1, 1, 'h70));
      exp_q.push_back(mk(1, 1, 0, 'h60));
      release_rst();
      run(4);
      @(negedge clk);
      monitor();
      check("mid_rdy1", req_ready[1], 1);
      #1 rst = 1'b0;
      #1;
      check("arst_out", {out_valid, out_sop, out_eop, out_d, out_src}, 0);
      check("arst_flags", {err_orphan, err_len, busy}, 0);
      check("arst_ready", req_ready, 0);
      check("arst_pre_drained", exp_q.size(), 0);
      reset_dut();
      for (int s = 0; s < NREQ; s++) begin
         push_pkt(s, 1, 'h80 + s);
         exp_q.push_back(mk(s, 1, 1, 'h80 + s));
      end
      release_rst();
      run(12);
      check("arst_post_drained", exp_q.size(), 0);

      // Randomized traffic with backpressure and in-packet source gaps
      for (int r = 0; r < 4; r++) begin
         reset_dut();
         for (int s = 0; s < NREQ; s++) begin
            int npk;
            npk = $urandom_range(0, 4);
            for (int p = 0; p < npk; p++) begin
               int len;
               len = $urandom_range(1, 6);
               for (int k = 0; k < len; k++)
                  push_beat(s, k == 0 || $urandom_range(0, 7) == 0, k == len - 1, $urandom_range(0, 255));
            end
         end
         model_expect(want_err);
         gap_en = 1'b1;
         rdy_rand = 1'b1;
         release_rst();
         cyc = 0;
         while (!(all_empty() && exp_q.size() == 0 && !busy && !out_valid) && cyc < 1500) begin
            cycle();
            cyc++;
         end
         check("rand_drain", cyc < 1500, 1);
         check("rand_err_len", err_len, want_err);
         check("rand_err_orphan", err_orphan, 0);
         check("rand_left", exp_q.size(), 0);
         gap_en = 1'b0;
         rdy_rand = 1'b0;
      end

      check("extra_beats", n_extra, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
